// File: rtl/mmio_uart_lite.sv
// AXI4-Lite console device: TX/RX byte FIFOs behind a four-register MMIO map,
// with outbound/inbound byte streams and a level interrupt.
module mmio_uart_lite #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  uncoreclk,
    input  logic                  uncore_rstn,
    input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr,
    input  logic                  s_axilite_awvalid,
    output logic                  s_axilite_awready,
    input  logic [31:0]           s_axilite_wdata,
    input  logic [3:0]            s_axilite_wstrb,
    input  logic                  s_axilite_wvalid,
    output logic                  s_axilite_wready,
    output logic [1:0]            s_axilite_bresp,
    output logic                  s_axilite_bvalid,
    input  logic                  s_axilite_bready,
    input  logic [ADDR_WIDTH-1:0] s_axilite_araddr,
    input  logic                  s_axilite_arvalid,
    output logic                  s_axilite_arready,
    output logic [31:0]           s_axilite_rdata,
    output logic [1:0]            s_axilite_rresp,
    output logic                  s_axilite_rvalid,
    input  logic                  s_axilite_rready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  intr
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [1:0] REG_RX = 2'd0, REG_TX = 2'd1, REG_STAT = 2'd2, REG_CTRL = 2'd3;

    logic          aw_held, w_held, bvalid_n, rvalid_n, aw_held_n, w_held_n;
    logic [1:0]    aw_reg;
    logic [7:0]    wdata_reg;
    logic          wstrb0_reg;
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] tx_count, rx_count, tx_count_n, rx_count_n;
    logic          ien, overrun, tx_done, ien_n, overrun_n, tx_done_n;

    logic          aw_hs, w_hs, ar_hs, wr_fire, wr_strb0, stat_rd;
    logic [1:0]    wr_addr, rd_addr;
    logic [7:0]    wr_data;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_clr, rx_clr, tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0]   stat_val, rd_val;
    logic          unused_bits;

    assign s_axilite_bresp = 2'b00;
    assign s_axilite_rresp = 2'b00;
    assign rx_ready        = 1'b1;
    assign tx_data         = tx_mem[tx_rd_ptr];
    assign unused_bits     = ^{s_axilite_awaddr[ADDR_WIDTH-1:4], s_axilite_awaddr[1:0],
                               s_axilite_araddr[ADDR_WIDTH-1:4], s_axilite_araddr[1:0],
                               s_axilite_wdata[31:8], s_axilite_wstrb[3:1]};

    // Handshakes, register decode and next-state for all control state
    always_comb begin
        aw_hs    = s_axilite_awvalid & s_axilite_awready;
        w_hs     = s_axilite_wvalid & s_axilite_wready;
        ar_hs    = s_axilite_arvalid & s_axilite_arready;
        wr_fire  = (aw_held | aw_hs) & (w_held | w_hs);
        wr_addr  = aw_held ? aw_reg : s_axilite_awaddr[3:2];
        wr_data  = w_held ? wdata_reg : s_axilite_wdata[7:0];
        wr_strb0 = w_held ? wstrb0_reg : s_axilite_wstrb[0];
        rd_addr  = s_axilite_araddr[3:2];

        tx_full  = (tx_count == CW'(DEPTH));
        tx_empty = (tx_count == '0);
        rx_full  = (rx_count == CW'(DEPTH));
        rx_empty = (rx_count == '0);

        // A FIFO clear suppresses any same-cycle push or pop on that FIFO
        tx_clr  = wr_fire & (wr_addr == REG_CTRL) & wr_data[0];
        rx_clr  = wr_fire & (wr_addr == REG_CTRL) & wr_data[1];
        tx_push = wr_fire & (wr_addr == REG_TX) & wr_strb0 & ~tx_full & ~tx_clr;
        tx_pop  = ~tx_empty & tx_ready & ~tx_clr;
        rx_push = rx_valid & ~rx_full & ~rx_clr;
        rx_pop  = ar_hs & (rd_addr == REG_RX) & ~rx_empty & ~rx_clr;
        stat_rd = ar_hs & (rd_addr == REG_STAT);

        tx_count_n = tx_clr ? '0 : tx_count + CW'(tx_push) - CW'(tx_pop);
        rx_count_n = rx_clr ? '0 : rx_count + CW'(rx_push) - CW'(rx_pop);

        ien_n = ien;
        if (wr_fire && wr_addr == REG_CTRL) ien_n = wr_data[4];
        // Sets win over the read-to-clear
        overrun_n = (rx_valid & rx_full) | (overrun & ~stat_rd);
        tx_done_n = (tx_pop & ~tx_push & (tx_count == CW'(1))) | (tx_done & ~stat_rd);

        stat_val = {25'b0, tx_done, overrun, ien, tx_full, tx_empty, rx_full, ~rx_empty};
        rd_val   = '0;
        case (rd_addr)
            REG_RX:   rd_val = rx_empty ? 32'b0 : {24'b0, rx_mem[rx_rd_ptr]};
            REG_STAT: rd_val = stat_val;
            default:  rd_val = '0;
        endcase

        aw_held_n = ~wr_fire & (aw_held | aw_hs);
        w_held_n  = ~wr_fire & (w_held | w_hs);
        bvalid_n  = wr_fire | (s_axilite_bvalid & ~s_axilite_bready);
        rvalid_n  = ar_hs | (s_axilite_rvalid & ~s_axilite_rready);
    end

    // Control state and registered outputs
    always_ff @(posedge uncoreclk) begin
        if (!uncore_rstn) begin
            aw_held           <= 1'b0;
            w_held            <= 1'b0;
            aw_reg            <= '0;
            wdata_reg         <= '0;
            wstrb0_reg        <= 1'b0;
            s_axilite_awready <= 1'b0;
            s_axilite_wready  <= 1'b0;
            s_axilite_bvalid  <= 1'b0;
            s_axilite_arready <= 1'b0;
            s_axilite_rvalid  <= 1'b0;
            s_axilite_rdata   <= '0;
            tx_wr_ptr         <= '0;
            tx_rd_ptr         <= '0;
            rx_wr_ptr         <= '0;
            rx_rd_ptr         <= '0;
            tx_count          <= '0;
            rx_count          <= '0;
            ien               <= 1'b0;
            overrun           <= 1'b0;
            tx_done           <= 1'b0;
            tx_valid          <= 1'b0;
            intr              <= 1'b0;
        end else begin
            aw_held           <= aw_held_n;
            w_held            <= w_held_n;
            if (aw_hs) aw_reg <= s_axilite_awaddr[3:2];
            if (w_hs) begin
                wdata_reg  <= s_axilite_wdata[7:0];
                wstrb0_reg <= s_axilite_wstrb[0];
            end
            s_axilite_awready <= ~aw_held_n & ~bvalid_n;
            s_axilite_wready  <= ~w_held_n & ~bvalid_n;
            s_axilite_bvalid  <= bvalid_n;
            s_axilite_arready <= ~rvalid_n;
            s_axilite_rvalid  <= rvalid_n;
            if (ar_hs) s_axilite_rdata <= rd_val;

            if (tx_clr) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
            end
            if (rx_clr) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
            end else begin
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
            end
            tx_count <= tx_count_n;
            rx_count <= rx_count_n;
            ien      <= ien_n;
            overrun  <= overrun_n;
            tx_done  <= tx_done_n;
            tx_valid <= (tx_count_n != '0);
            intr     <= ien_n & ((rx_count_n != '0) | tx_done_n);
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the counts
    always_ff @(posedge uncoreclk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= wr_data;
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end
endmodule

// File: tb/tb_mmio_uart_lite.sv
// Self-checking bench for mmio_uart_lite: scoreboard queues for AXI read data
// and TX stream bytes, plus directed checks on handshakes and interrupt timing.
module tb_mmio_uart_lite;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, intr;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          tx_seen  = 0;
    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];

    mmio_uart_lite #(.DEPTH(16), .ADDR_WIDTH(32)) dut (
        .uncoreclk(clk), .uncore_rstn(rstn),
        .s_axilite_awaddr(awaddr), .s_axilite_awvalid(awvalid), .s_axilite_awready(awready),
        .s_axilite_wdata(wdata), .s_axilite_wstrb(wstrb), .s_axilite_wvalid(wvalid),
        .s_axilite_wready(wready), .s_axilite_bresp(bresp), .s_axilite_bvalid(bvalid),
        .s_axilite_bready(bready), .s_axilite_araddr(araddr), .s_axilite_arvalid(arvalid),
        .s_axilite_arready(arready), .s_axilite_rdata(rdata), .s_axilite_rresp(rresp),
        .s_axilite_rvalid(rvalid), .s_axilite_rready(rready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives AW and W together; returns in the cycle bvalid is observed
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int  n = 0;
        logic aw_go, w_go;
        awaddr = 32'(addr); wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        while ((awvalid || wvalid) && n < 20) begin
            aw_go = awvalid & awready;
            w_go  = wvalid & wready;
            tick();
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (n >= 20) check("aw_w_handshake_timeout", 32'(1), 32'(0));
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        check("bvalid", 32'(bvalid), 32'(1));
        check("bresp", 32'(bresp), 32'(0));
    endtask

    task automatic tx_write(input logic [7:0] data);
        if (tx_q.size() < 16) tx_q.push_back(data);
        axi_write(4'h4, 32'(data), 4'h1);
    endtask

    // Queues the expected data; returns in the cycle rvalid is observed
    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
        int  n = 0;
        logic go;
        rd_q.push_back(exp);
        araddr = 32'(addr); arvalid = 1'b1;
        while (arvalid && n < 20) begin
            go = arready;
            tick();
            if (go) arvalid = 1'b0;
            n++;
        end
        arvalid = 1'b0;
        if (n >= 20) check("ar_handshake_timeout", 32'(1), 32'(0));
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        check("rvalid", 32'(rvalid), 32'(1));
    endtask

    always @(negedge clk) begin
        if (rvalid && rready) begin
            if (rd_q.size() == 0) check("r_unexpected", 32'(1), 32'(0));
            else check("rdata", rdata, rd_q.pop_front());
            check("rresp", 32'(rresp), 32'(0));
        end
    end

    always @(negedge clk) begin
        if (rstn && tx_valid && tx_ready) begin
            tx_seen++;
            if (tx_q.size() == 0) check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
            else check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen0;
        int n;
        rstn = 1'b0; awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        tick(); tick();
        check("rst_awready", 32'(awready), 32'(0));
        check("rst_wready", 32'(wready), 32'(0));
        check("rst_arready", 32'(arready), 32'(0));
        check("rst_bvalid", 32'(bvalid), 32'(0));
        check("rst_rvalid", 32'(rvalid), 32'(0));
        check("rst_rdata", rdata, 32'(0));
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_intr", 32'(intr), 32'(0));
        rstn = 1'b1;
        tick();
        check("post_rst_awready", 32'(awready), 32'(1));
        check("post_rst_arready", 32'(arready), 32'(1));

        // Single TX byte, AW and W together, drained immediately
        tx_ready = 1'b1;
        tx_write(8'h41);
        check("t1_tx_valid", 32'(tx_valid), 32'(1));
        check("t1_tx_data", 32'(tx_data), 32'h41);
        tick();
        check("t1_tx_valid_one_cycle", 32'(tx_valid), 32'(0));
        check("t1_bvalid_done", 32'(bvalid), 32'(0));
        axi_read(4'h8, 32'h44);
        tx_ready = 1'b0;
        tick();

        // AW three cycles ahead of W, with the B channel back-pressured
        bready = 1'b0;
        tx_q.push_back(8'h5A);
        awaddr = 32'h4; awvalid = 1'b1;
        check("t2_awready_pre", 32'(awready), 32'(1));
        tick(); awvalid = 1'b0;
        check("t2_awready_held", 32'(awready), 32'(0));
        tick(); tick();
        check("t2_awready_wait", 32'(awready), 32'(0));
        check("t2_bvalid_wait", 32'(bvalid), 32'(0));
        wdata = 32'h5A; wstrb = 4'h1; wvalid = 1'b1;
        check("t2_wready_pre", 32'(wready), 32'(1));
        tick(); wvalid = 1'b0;
        awaddr = 32'h4; wdata = 32'hEE; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_bvalid_hold", 32'(bvalid), 32'(1));
            check("t2_awready_blocked", 32'(awready), 32'(0));
            check("t2_wready_blocked", 32'(wready), 32'(0));
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick();
        check("t2_bvalid_cleared", 32'(bvalid), 32'(0));

        // Overfill RX, then drain it in order
        for (int i = 0; i <= 16; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        axi_read(4'h8, 32'h23);
        for (int i = 0; i < 16; i++) axi_read(4'h0, 32'(i));
        axi_read(4'h0, 32'h0);
        axi_read(4'h8, 32'h00);
        tick();

        // RX-driven interrupt
        axi_write(4'hC, 32'h10, 4'hF);
        tick();
        check("t4_intr_idle", 32'(intr), 32'(0));
        rx_valid = 1'b1; rx_data = 8'h77;
        tick(); rx_valid = 1'b0;
        check("t4_intr_rise", 32'(intr), 32'(1));
        axi_read(4'h0, 32'h77);
        tick();
        check("t4_intr_fall", 32'(intr), 32'(0));

        // Fill TX to the brim, overflow once, then drain
        tx_q.delete();
        axi_write(4'hC, 32'h11, 4'hF);
        for (int i = 0; i <= 16; i++) tx_write(8'hA0 + 8'(i));
        tick();
        axi_read(4'h8, 32'h18);
        check("t5_intr_full", 32'(intr), 32'(0));
        seen0 = tx_seen;
        tx_ready = 1'b1;
        n = 0;
        while (tx_valid && n < 40) begin tick(); n++; end
        check("t5_tx_count", 32'(tx_seen - seen0), 32'(16));
        check("t5_tx_valid_end", 32'(tx_valid), 32'(0));
        check("t5_intr_tx_done", 32'(intr), 32'(1));
        axi_read(4'h8, 32'h54);
        tick();
        check("t5_intr_cleared", 32'(intr), 32'(0));
        tx_ready = 1'b0;

        // CTRL clear of both FIFOs racing an RX push
        tx_write(8'h11);
        tx_write(8'h22);
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1; rx_data = 8'h30 + 8'(i);
            tick();
        end
        check("t6_intr_rx", 32'(intr), 32'(1));
        awaddr = 32'hC; wdata = 32'h13; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        rx_data = 8'h99;
        check("t6_awready", 32'(awready), 32'(1));
        check("t6_wready", 32'(wready), 32'(1));
        tick();
        awvalid = 1'b0; wvalid = 1'b0; rx_valid = 1'b0;
        tx_q.delete();
        check("t6_bvalid", 32'(bvalid), 32'(1));
        tick();
        axi_read(4'h8, 32'h14);
        axi_read(4'h0, 32'h0);
        check("t6_intr", 32'(intr), 32'(0));
        tick();

        // Reset mid-transaction drops a held AW and empties RX
        axi_write(4'hC, 32'h00, 4'hF);
        tick();
        rx_valid = 1'b1; rx_data = 8'h5C;
        awaddr = 32'h4; awvalid = 1'b1;
        tick();
        awvalid = 1'b0; rx_valid = 1'b0;
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        wdata = 32'h33; wstrb = 4'h1; wvalid = 1'b1;
        tick(); wvalid = 1'b0;
        tick();
        check("rst_mid_bvalid", 32'(bvalid), 32'(0));
        axi_read(4'h8, 32'h04);
        tick(); tick();

        check("rd_q_drained", 32'(rd_q.size()), 32'(0));
        check("tx_q_drained", 32'(tx_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
